fpu_seq_ctrl: RTL
=================

# fpu_seq_ctrl

Multi-cycle sequencer for the floating-point execution unit. Accepts one decoded FP operation at a time from the decode/control stage, issues it to the FPU, counts the operation's fixed latency, stalls the integer pipeline while the FPU is busy and emits a single-cycle FP register-file write-back. It sits between the control unit's FP op-select field and the FPU/FP register file.

## Interface
- LAT_ADD, 3: EXEC cycles for add/sub (op 0)
- LAT_MUL, 4: EXEC cycles for multiply (op 1)
- LAT_DIV, 16: EXEC cycles for divide (op 2)
- LAT_MISC, 1: EXEC cycles for ops 3–9
- in_clk  input  1  clock, all state on rising edge
- in_rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  FP op presented by decode
- in_fp_op  input  4  op select: 0 add/sub, 1 mul, 2 div, 3 min, 4 max, 5 cvt fp-fp, 6 cvt fp-int, 7 sgnj, 8 cmp, 9 mv; 10–15 illegal
- in_rd  input  5  destination register
- in_flush  input  1  pipeline flush (branch/jump redirect)
- out_fpu_start  output  1  one-cycle issue strobe to FPU
- out_fpu_op  output  4  op held for the whole EXEC phase
- out_stall  output  1  pipeline stall
- out_wb_en  output  1  one-cycle FP register-file write enable
- out_wb_rd  output  5  write-back destination
- out_illegal  output  1  one-cycle illegal-op pulse

## Operation
- States: IDLE, EXEC, WB. Reset (in_rst_n low, asynchronous): state IDLE, counter 0, every output 0.
- IDLE: in_valid with legal op → capture op/rd, load counter with LAT(op)−1, go EXEC. Illegal op → out_illegal pulses next cycle, stay IDLE. in_valid with in_flush in same cycle → ignored.
- EXEC: counter decrements each cycle; at 0 → WB. in_flush in EXEC → IDLE next edge, no write-back, counter cleared.
- WB: out_wb_en=1, out_wb_rd=captured rd; unconditionally → IDLE. in_flush in WB does not suppress write-back (op committed).
- Counter 5 bits; each LAT parameter must be 1..31 (elaboration-time check).
- in_valid while out_stall=1 is ignored; decode holds the instruction externally.

## Timing
- Accept at edge 0 → cycles 1..LAT are EXEC, out_fpu_start=1 in cycle 1 only, out_fpu_op valid cycles 1..LAT.
- Cycle LAT+1: WB, out_wb_en=1. Cycle LAT+2: IDLE; a new in_valid sampled at that edge is accepted (issue-to-issue = LAT+2 cycles).
- out_stall registered: 1 in cycles 1..LAT+1, 0 otherwise.
- All outputs registered; no combinational input-to-output path.

## Configuration
- FPU_DIV_EN defined: op 2 is legal, sequenced with LAT_DIV.
- FPU_DIV_EN undefined: op 2 is treated as illegal (out_illegal pulse, no issue); LAT_DIV unused.

## Structure
- Package fpu_seq_pkg: op-code constants (FP_OP_ADD..FP_OP_MV), state encoding (IDLE/EXEC/WB), counter width constant.
- One combinational sub-module fpu_lat_lookup: op → {legal, latency−1}, honouring FPU_DIV_EN.

## Test plan
- Reset mid-EXEC of mul: assert in_rst_n=0 → all outputs 0 immediately; after release, IDLE, no wb.
- Add (op 0, rd=5), LAT_ADD=3: start in cycle 1, stall cycles 1–4, wb_en with wb_rd=5 in cycle 4, new op accepted at edge 5.
- Div (op 2) with FPU_DIV_EN: 16 EXEC cycles, wb cycle 17; without macro: out_illegal in cycle 1, no start, no stall.
- Flush in EXEC cycle 2 of mul: IDLE at cycle 3, no out_wb_en; flush during WB cycle: out_wb_en still 1.
- Back-to-back mv (op 9) then cmp (op 8): each 1 EXEC + 1 WB, second accepted exactly 3 cycles after first.
- Op 12: out_illegal one cycle, out_stall stays 0, next legal op accepted the following cycle.

Source files
------------

// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FP sequencer: op-code constants, FSM state
// encoding and field widths.
package fpu_seq_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned CNT_W = 5;

    localparam logic [OP_W-1:0] FP_OP_ADD    = 4'd0;
    localparam logic [OP_W-1:0] FP_OP_MUL    = 4'd1;
    localparam logic [OP_W-1:0] FP_OP_DIV    = 4'd2;
    localparam logic [OP_W-1:0] FP_OP_MIN    = 4'd3;
    localparam logic [OP_W-1:0] FP_OP_MAX    = 4'd4;
    localparam logic [OP_W-1:0] FP_OP_CVTFF  = 4'd5;
    localparam logic [OP_W-1:0] FP_OP_CVTFI  = 4'd6;
    localparam logic [OP_W-1:0] FP_OP_SGNJ   = 4'd7;
    localparam logic [OP_W-1:0] FP_OP_CMP    = 4'd8;
    localparam logic [OP_W-1:0] FP_OP_MV     = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/fpu_seq_ctrl_if.sv
// Decode <-> FP sequencer handshake bundle.
//   master: decode/control side (drives in_*, observes out_*)
//   slave : sequencer side (observes in_*, drives out_*)
interface fpu_seq_ctrl_if;

    logic                           in_valid;
    logic [fpu_seq_pkg::OP_W-1:0]   in_fp_op;
    logic [fpu_seq_pkg::RD_W-1:0]   in_rd;
    logic                           in_flush;
    logic                           out_fpu_start;
    logic [fpu_seq_pkg::OP_W-1:0]   out_fpu_op;
    logic                           out_stall;
    logic                           out_wb_en;
    logic [fpu_seq_pkg::RD_W-1:0]   out_wb_rd;
    logic                           out_illegal;

    modport master (
        output in_valid, in_fp_op, in_rd, in_flush,
        input  out_fpu_start, out_fpu_op, out_stall, out_wb_en, out_wb_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_fp_op, in_rd, in_flush,
        output out_fpu_start, out_fpu_op, out_stall, out_wb_en, out_wb_rd, out_illegal
    );

endinterface

// File: rtl/fpu_lat_lookup.sv
// Op-code to {legal, latency-1} decode for the FP sequencer.
// Divide is only legal when FPU_DIV_EN is defined.
//   op       : FP op select
//   legal_c  : op is sequenced by this build
//   lat_m1_c : EXEC cycles minus one (counter preload)
module fpu_lat_lookup
    import fpu_seq_pkg::*;
#(
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned LAT_MUL  = 4,
    parameter int unsigned LAT_DIV  = 16,
    parameter int unsigned LAT_MISC = 1
) (
    input  logic [OP_W-1:0]  op,
    output logic             legal_c,
    output logic [CNT_W-1:0] lat_m1_c
);

    localparam int unsigned LAT_MAX = (1 << CNT_W) - 1;

    // Latencies must fit the down-counter and be at least one cycle.
    if (LAT_ADD == 0 || LAT_ADD > LAT_MAX || LAT_MUL == 0 || LAT_MUL > LAT_MAX ||
        LAT_DIV == 0 || LAT_DIV > LAT_MAX || LAT_MISC == 0 || LAT_MISC > LAT_MAX) begin : g_lat_range
        $error("fpu_lat_lookup: every latency must be within 1..%0d", LAT_MAX);
    end

    always_comb begin
        legal_c  = 1'b0;
        lat_m1_c = '0;
        case (op)
            FP_OP_ADD: begin
                legal_c  = 1'b1;
                lat_m1_c = CNT_W'(LAT_ADD - 1);
            end
            FP_OP_MUL: begin
                legal_c  = 1'b1;
                lat_m1_c = CNT_W'(LAT_MUL - 1);
            end
            FP_OP_DIV: begin
`ifdef FPU_DIV_EN
                legal_c  = 1'b1;
                lat_m1_c = CNT_W'(LAT_DIV - 1);
`else
                legal_c  = 1'b0;
`endif
            end
            FP_OP_MIN, FP_OP_MAX, FP_OP_CVTFF, FP_OP_CVTFI,
            FP_OP_SGNJ, FP_OP_CMP, FP_OP_MV: begin
                legal_c  = 1'b1;
                lat_m1_c = CNT_W'(LAT_MISC - 1);
            end
            default: begin
                legal_c  = 1'b0;
                lat_m1_c = '0;
            end
        endcase
    end

endmodule

// File: rtl/fpu_seq_ctrl.sv
// Multi-cycle FP sequencer: accepts one decoded FP op, issues it to the FPU,
// counts its fixed latency while stalling the pipeline, then emits a
// one-cycle FP register-file write-back. All outputs are registered.
// Optional feature macro: FPU_DIV_EN (enables sequencing of divide).
//   in_clk, in_rst_n : clock, asynchronous active-low reset
//   bus (slave)      : in_valid/in_fp_op/in_rd/in_flush from decode;
//                      out_fpu_start/out_fpu_op/out_stall/out_wb_en/
//                      out_wb_rd/out_illegal to FPU, pipeline and FP RF
module fpu_seq_ctrl
    import fpu_seq_pkg::*;
#(
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned LAT_MUL  = 4,
    parameter int unsigned LAT_DIV  = 16,
    parameter int unsigned LAT_MISC = 1
) (
    input  logic          in_clk,
    input  logic          in_rst_n,
    fpu_seq_ctrl_if.slave bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RD_W-1:0]    rd_q, rd_d;
    logic               start_q, start_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic               stall_q, stall_d;
    logic               wb_en_q, wb_en_d;
    logic [RD_W-1:0]    wb_rd_q, wb_rd_d;
    logic               illegal_q, illegal_d;

    logic               legal_c;
    logic [CNT_W-1:0]   lat_m1_c;

    fpu_lat_lookup #(
        .LAT_ADD  (LAT_ADD),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV),
        .LAT_MISC (LAT_MISC)
    ) u_lat (
        .op       (bus.in_fp_op),
        .legal_c  (legal_c),
        .lat_m1_c (lat_m1_c)
    );

    // Next-state and next-output logic; outputs default to their idle values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        start_d   = 1'b0;
        op_d      = '0;
        stall_d   = 1'b0;
        wb_en_d   = 1'b0;
        wb_rd_d   = '0;
        illegal_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A flush in the same cycle cancels the presented op entirely.
                if (bus.in_valid && !bus.in_flush) begin
                    if (legal_c) begin
                        state_d = EXEC;
                        cnt_d   = lat_m1_c;
                        rd_d    = bus.in_rd;
                        start_d = 1'b1;
                        op_d    = bus.in_fp_op;
                        stall_d = 1'b1;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (bus.in_flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = WB;
                    stall_d = 1'b1;
                    wb_en_d = 1'b1;
                    wb_rd_d = rd_q;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    op_d    = op_q;
                    stall_d = 1'b1;
                end
            end
            WB: begin
                // The op is committed; a flush here has no effect.
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_q      <= '0;
            start_q   <= 1'b0;
            op_q      <= '0;
            stall_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            start_q   <= start_d;
            op_q      <= op_d;
            stall_q   <= stall_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.out_fpu_start = start_q;
    assign bus.out_fpu_op    = op_q;
    assign bus.out_stall     = stall_q;
    assign bus.out_wb_en     = wb_en_q;
    assign bus.out_wb_rd     = wb_rd_q;
    assign bus.out_illegal   = illegal_q;

endmodule
